// File: rtl/code_entry_if.sv
// Code hand-off bundle between code_entry (master) and the checker (slave).
// Carries the packed digits, the valid/ack handshake and the set/attempt tag.
interface code_entry_if #(
  parameter int DIGITS = 4
);
  logic [2*DIGITS-1:0] code;
  logic                code_valid;
  logic                code_is_set;
  logic                code_ack;

  modport master (
    output code,
    output code_valid,
    output code_is_set,
    input  code_ack
  );

  modport slave (
    input  code,
    input  code_valid,
    input  code_is_set,
    output code_ack
  );
endinterface

// File: rtl/code_entry.sv
// Push-button digit entry: synchronize/debounce key, collect DIGITS 2-bit digits, present via valid/ack.
// Optional inactivity timeout on partial entries when CODE_ENTRY_TIMEOUT_EN is defined.
//
// state   | meaning
// COLLECT | accepting digits, digit_count < DIGITS
// PRESENT | full code presented, waiting for code_ack
module code_entry #(
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         key_i,
  input  logic [1:0]                   bits_i,
  input  logic                         mode_set_i,
  input  logic                         clear_i,
  code_entry_if.master                 code_if,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count_o,
  output logic                         digit_stb_o,
  output logic                         timeout_o
);

  localparam int CW  = $clog2(DIGITS + 1);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic {COLLECT = 1'b0, PRESENT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [2*DIGITS-1:0] code_q, code_d;
  logic [CW-1:0]       count_q, count_d;
  logic                is_set_q, is_set_d;
  logic                stb_q, stb_d;

  logic                key_meta_q, key_s_q;
  logic                key_db_q, key_db_d;
  logic                key_db_prev_q;
  logic [DBW-1:0]      db_cnt_q, db_cnt_d;
  logic                press;
  logic                accept;

  // Debouncer: key_db follows key_s only after it has differed for DEBOUNCE_CYCLES cycles
  always_comb begin
    key_db_d = key_db_q;
    db_cnt_d = '0;
    if (key_s_q != key_db_q) begin
      if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
        key_db_d = key_s_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign press  = key_db_q & ~key_db_prev_q;
  assign accept = (state_q == COLLECT) && press && !clear_i && (count_q < CW'(DIGITS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_meta_q    <= 1'b0;
      key_s_q       <= 1'b0;
      key_db_q      <= 1'b0;
      key_db_prev_q <= 1'b0;
      db_cnt_q      <= '0;
    end else begin
      key_meta_q    <= key_i;
      key_s_q       <= key_meta_q;
      key_db_q      <= key_db_d;
      key_db_prev_q <= key_db_q;
      db_cnt_q      <= db_cnt_d;
    end
  end

`ifdef CODE_ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] timer_q, timer_d;
  logic          timeout_q;
  logic          expire;

  assign expire = (state_q == COLLECT) && !clear_i && !accept && (count_q != '0)
                  && (timer_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    timer_d = '0;
    if ((state_q == COLLECT) && !clear_i && !accept && !expire && (count_q != '0)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      timeout_q <= expire;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic expire;

  assign expire    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    count_d  = count_q;
    is_set_d = is_set_q;
    stb_d    = 1'b0;
    if (clear_i) begin
      code_d  = '0;
      count_d = '0;
      state_d = COLLECT;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (accept) begin
            for (int i = 0; i < DIGITS; i++) begin
              if (count_q == CW'(i)) code_d[2*i +: 2] = bits_i;
            end
            count_d = count_q + 1'b1;
            stb_d   = 1'b1;
            if (count_q == CW'(DIGITS - 1)) begin
              state_d  = PRESENT;
              is_set_d = mode_set_i;
            end
          end else if (expire) begin
            code_d  = '0;
            count_d = '0;
          end
        end
        PRESENT: begin
          // A press landing with the ack is dropped, not carried into the next code
          if (code_if.code_ack) begin
            code_d  = '0;
            count_d = '0;
            state_d = COLLECT;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= COLLECT;
      code_q   <= '0;
      count_q  <= '0;
      is_set_q <= 1'b0;
      stb_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      count_q  <= count_d;
      is_set_q <= is_set_d;
      stb_q    <= stb_d;
    end
  end

  assign code_if.code        = code_q;
  assign code_if.code_valid  = (state_q == PRESENT);
  assign code_if.code_is_set = is_set_q;
  assign digit_count_o       = count_q;
  assign digit_stb_o         = stb_q;

endmodule

// File: tb/tb_code_entry.sv
// Self-checking bench for code_entry: table-driven entry, hand-written corner sequences,
// and randomized press/ack/clear traffic against a queue-based model of the entry rules.
module tb_code_entry;
  localparam int DIGITS = 4;
  localparam int DEB    = 4;
  localparam int TO     = 20;
  localparam int CW     = $clog2(DIGITS + 1);
  localparam int LAT    = DEB + 3;  // ticks from driving key just after an edge to digit_stb seen

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              key = 1'b0;
  logic [1:0]        bits = 2'd0;
  logic              mode_set = 1'b0;
  logic              clear = 1'b0;
  logic [CW-1:0]     digit_count;
  logic              digit_stb;
  logic              timeout;

  code_entry_if #(.DIGITS(DIGITS)) cif ();

  code_entry #(
    .DIGITS(DIGITS),
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_i(key),
    .bits_i(bits),
    .mode_set_i(mode_set),
    .clear_i(clear),
    .code_if(cif),
    .digit_count_o(digit_count),
    .digit_stb_o(digit_stb),
    .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_stb_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: ordered list of entered digits plus presentation flags
  logic [1:0] mq[$];
  bit         m_present = 0;
  bit         m_is_set  = 0;

  typedef struct {
    logic [1:0] b;
    bit         m;
    int         exp_cnt;
    logic [7:0] exp_code;
    bit         exp_valid;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [2*DIGITS-1:0] m_code();
    logic [2*DIGITS-1:0] c;
    c = '0;
    for (int i = 0; i < mq.size(); i++) c = c | ((2*DIGITS)'(mq[i]) << (2*i));
    return c;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_present = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " count"}, 32'(digit_count), 32'(mq.size()));
    chk({tag, " code"}, 32'(cif.code), 32'(m_code()));
    chk({tag, " valid"}, 32'(cif.code_valid), 32'(m_present));
    chk({tag, " is_set"}, 32'(cif.code_is_set), 32'(m_is_set));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, output int stbs, output int tos);
    stbs = 0;
    tos  = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (digit_stb) stbs++;
      if (timeout) tos++;
    end
  endtask

  // One clean press/release; optional ack or clear lands on the press edge
  task automatic press(input logic [1:0] b, input bit m, input bit with_ack, input bit with_clear);
    int  seen;
    int  lat;
    bit  acc;
    seen = 0;
    lat  = -1;
    acc  = !with_clear && !m_present;
    bits = b;
    mode_set = m;
    key = 1'b1;
    for (int n = 1; n <= LAT + 3; n++) begin
      if (n == LAT) begin
        cif.code_ack = with_ack;
        clear = with_clear;
      end
      tick();
      if (n == LAT) begin
        cif.code_ack = 1'b0;
        clear = 1'b0;
      end
      if (digit_stb) begin
        seen++;
        lat = n;
        last_stb_cyc = cyc;
      end
    end
    key = 1'b0;
    for (int n = 0; n < 2*DEB + 4; n++) begin
      tick();
      if (digit_stb) seen++;
    end
    if (acc) begin
      chk("press stb count", 32'(seen), 32'd1);
      chk("press latency", 32'(lat), 32'(LAT));
    end else begin
      chk("dropped press stb", 32'(seen), 32'd0);
    end
    if (with_clear) begin
      model_clear();
    end else if (m_present) begin
      if (with_ack) model_clear();
    end else begin
      mq.push_back(b);
      if (mq.size() == DIGITS) begin
        m_present = 1;
        m_is_set  = m;
      end
    end
  endtask

  task automatic ack_pulse();
    cif.code_ack = 1'b1;
    tick();
    cif.code_ack = 1'b0;
    if (m_present) model_clear();
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int stbs, tos, seen, lat, r;
    cif.code_ack = 1'b0;

    tbl[0] = '{2'd2, 1'b0, 1, 8'h02, 1'b0};
    tbl[1] = '{2'd1, 1'b0, 2, 8'h06, 1'b0};
    tbl[2] = '{2'd3, 1'b0, 3, 8'h36, 1'b0};
    tbl[3] = '{2'd0, 1'b0, 4, 8'h36, 1'b1};

    // Reset state
    tick();
    tick();
    chk("rst code", 32'(cif.code), 32'd0);
    chk("rst valid", 32'(cif.code_valid), 32'd0);
    chk("rst is_set", 32'(cif.code_is_set), 32'd0);
    chk("rst count", 32'(digit_count), 32'd0);
    chk("rst stb", 32'(digit_stb), 32'd0);
    chk("rst timeout", 32'(timeout), 32'd0);
    reset = 1'b0;
    tick();

    // Clean entry from the table
    for (int i = 0; i < 4; i++) begin
      press(tbl[i].b, tbl[i].m, 1'b0, 1'b0);
      chk("tbl count", 32'(digit_count), 32'(tbl[i].exp_cnt));
      chk("tbl code", 32'(cif.code), 32'(tbl[i].exp_code));
      chk("tbl valid", 32'(cif.code_valid), 32'(tbl[i].exp_valid));
    end
    chk("tbl is_set", 32'(cif.code_is_set), 32'd0);
    ack_pulse();
    chk("ack code", 32'(cif.code), 32'd0);
    chk("ack valid", 32'(cif.code_valid), 32'd0);
    chk("ack count", 32'(digit_count), 32'd0);
    chk("ack stb", 32'(digit_stb), 32'd0);

    // Debounce: toggle every 2 cycles for 20 cycles, then hold high
    bits = 2'd1;
    mode_set = 1'b0;
    seen = 0;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      key = ((i / 2) % 2 == 0);
      tick();
      if (digit_stb) seen++;
    end
    key = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (digit_stb) begin
        seen++;
        lat = n;
      end
    end
    key = 1'b0;
    idle(2*DEB + 4, stbs, tos);
    seen += stbs;
    chk("debounce stb count", 32'(seen), 32'd1);
    chk("debounce latency", 32'(lat), 32'(LAT));
    mq.push_back(2'd1);
    check_model("debounce");
    clear_pulse();
    check_model("clear");

    // Handshake hold with mode_set=1
    for (int i = 0; i < DIGITS; i++) press(2'($urandom_range(0, 3)), 1'b1, 1'b0, 1'b0);
    check_model("full set");
    for (int i = 0; i < 5; i++) press(2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
    idle(50, stbs, tos);
    chk("hold stb", 32'(stbs), 32'd0);
    check_model("hold");
    press(2'd3, 1'b0, 1'b1, 1'b0);
    check_model("ack+press");

    // Clear priority over a press
    press(2'd1, 1'b0, 1'b0, 1'b0);
    press(2'd2, 1'b0, 1'b0, 1'b0);
    check_model("two digits");
    press(2'd3, 1'b0, 1'b0, 1'b1);
    check_model("clear+press");

    // Asynchronous reset while presenting
    for (int i = 0; i < DIGITS; i++) press(2'($urandom_range(0, 3)), 1'b1, 1'b0, 1'b0);
    chk("pre-reset valid", 32'(cif.code_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async rst code", 32'(cif.code), 32'd0);
    chk("async rst valid", 32'(cif.code_valid), 32'd0);
    chk("async rst is_set", 32'(cif.code_is_set), 32'd0);
    chk("async rst count", 32'(digit_count), 32'd0);
    tick();
    reset = 1'b0;
    model_clear();
    m_is_set = 0;
    tick();
    press(2'd2, 1'b0, 1'b0, 1'b0);
    check_model("post reset");
    clear_pulse();

    // Randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) press(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      else if (r == 6) press(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      else if (r <= 8) ack_pulse();
      else clear_pulse();
      check_model("random");
    end
    clear_pulse();

`ifdef CODE_ENTRY_TIMEOUT_EN
    press(2'd2, 1'b0, 1'b0, 1'b0);
    lat = -1;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (timeout) begin
        seen++;
        lat = cyc - last_stb_cyc;
      end
    end
    model_clear();
    chk("timeout pulses", 32'(seen), 32'd1);
    chk("timeout delay", 32'(lat), 32'(TO));
    check_model("after timeout");
    for (int i = 0; i < DIGITS; i++) press(2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
    idle(100, stbs, tos);
    chk("present no timeout", 32'(tos), 32'd0);
    check_model("present idle");
    ack_pulse();
`else
    press(2'd2, 1'b0, 1'b0, 1'b0);
    idle(60, stbs, tos);
    chk("no timeout", 32'(tos), 32'd0);
    check_model("partial persists");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
